// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, registered outputs only.
module seq_divider #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [DWIDTH-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [DWIDTH-1:0] dvs_q, dvs_d;
  logic [DWIDTH:0]   prem_q, prem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [DWIDTH-1:0] rem_q, rem_d;
  logic              dbz_q, dbz_d;

  logic [DWIDTH:0]   shifted;
  logic [DWIDTH:0]   trial;
  logic              fits;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // The working dividend register doubles as the quotient accumulator:
  // each cycle its MSB moves into the partial remainder and the new
  // quotient bit enters at the LSB.
  always_comb begin
    shifted = (prem_q << 1) | {{DWIDTH{1'b0}}, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    fits    = (shifted >= {1'b0, dvs_q});
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          prem_d = '0;
          dbz_d  = 1'b0;
          if (divisor == '0) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
            quo_d  = '1;
            rem_d  = '0;
          end else begin
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        prem_d = fits ? trial : shifted;
        dvd_d  = {dvd_q[WIDTH-2:0], fits};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = {dvd_q[WIDTH-2:0], fits};
          rem_d   = prem_d[DWIDTH-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8, DWIDTH=4).
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int vectors    = 0;
  int miscompares = 0;

  seq_divider #(.WIDTH(8), .DWIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Start one division; elat is edges from accept to done (8, or 0 for /0).
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er,
                         input logic edbz, input int elat, input string tag);
    int cyc;
    int busy_bad;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 0;
    busy_bad = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      cyc++;
    end
    if (busy !== 1'b0) busy_bad++;
    vectors++;
    if (cyc !== elat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected %0d", tag, cyc, elat);
    end
    vectors++;
    if (busy_bad !== 0) begin
      miscompares++;
      $display("FAIL %s busy_profile: got %0d bad cycles expected 0", tag, busy_bad);
    end
    vectors++;
    if (quotient !== eq) begin
      miscompares++;
      $display("FAIL %s quotient: got %0d expected %0d", tag, quotient, eq);
    end
    vectors++;
    if (remainder !== er) begin
      miscompares++;
      $display("FAIL %s remainder: got %0d expected %0d", tag, remainder, er);
    end
    vectors++;
    if (div_by_zero !== edbz) begin
      miscompares++;
      $display("FAIL %s div_by_zero: got %0b expected %0b", tag, div_by_zero, edbz);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_pulse: got %0b expected 0", tag, done);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0",
               {busy, done, quotient, remainder, div_by_zero});
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_div(8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8, "200/7");
    run_div(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8, "255/1");
    run_div(8'd3,   4'd15, 8'd0,   4'd3, 1'b0, 8, "3/15");
    run_div(8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8, "255/15");
    run_div(8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 8, "254/15");
  endtask

  task automatic test_div_zero();
    run_div(8'd90, 4'd0, 8'd255, 4'd0, 1'b1, 0, "90/0");
    repeat (3) @(negedge clk);
    vectors++;
    if ({div_by_zero, quotient, done} !== {1'b1, 8'd255, 1'b0}) begin
      miscompares++;
      $display("FAIL dbz_hold: got dbz=%0b q=%0d done=%0b expected 1 255 0",
               div_by_zero, quotient, done);
    end
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 4'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL dbz_clear: got %0b expected 0", div_by_zero);
    end
    repeat (12) @(negedge clk);
    vectors++;
    if ({quotient, remainder} !== {8'd10, 4'd0}) begin
      miscompares++;
      $display("FAIL 50/5 result: got %0d r %0d expected 10 r 0", quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    dividend = 8'd195;
    divisor  = 4'd13;
    start    = 1'b1;
    @(negedge clk);
    cyc = 0;
    // start stays high while operands are scrambled; nothing must be re-sampled
    while (done !== 1'b1 && cyc < 20) begin
      dividend = 8'd1;
      divisor  = 4'd0;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== 8) begin
      miscompares++;
      $display("FAIL b2b_first latency: got %0d expected 8", cyc);
    end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {8'd15, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_first result: got %0d r %0d dbz %0b expected 15 r 0 dbz 0",
               quotient, remainder, div_by_zero);
    end
    dividend = 8'd100;
    divisor  = 4'd9;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept busy: got %0b expected 1", busy);
    end
    while (done !== 1'b1 && cyc < 20) begin
      start = cyc[0];
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    vectors++;
    if (cyc !== 8) begin
      miscompares++;
      $display("FAIL b2b_second latency: got %0d expected 8", cyc);
    end
    vectors++;
    if ({quotient, remainder} !== {8'd11, 4'd1}) begin
      miscompares++;
      $display("FAIL b2b_second result: got %0d r %0d expected 11 r 1", quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int done_seen;
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_mid outputs: got %h expected 0",
               {busy, done, quotient, remainder, div_by_zero});
    end
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    vectors++;
    if (done_seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid aborted: got %0d done/busy cycles expected 0", done_seen);
    end
    run_div(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8, "post_reset 200/7");
  endtask

  task automatic test_sweep();
    logic [7:0] p;
    logic [7:0] eq;
    logic [3:0] er;
    logic [3:0] bb;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        p  = 8'(a * b);
        bb = 4'(b);
        if (b == 0) begin
          run_div(p, bb, 8'hFF, 4'd0, 1'b1, 0, $sformatf("sweep %0d/%0d", p, b));
        end else begin
          eq = 8'(p / bb);
          er = 4'(p % bb);
          if (eq !== 8'(a) || er !== 4'd0) $display("note: model disagreement at %0d/%0d", p, b);
          run_div(p, bb, eq, er, 1'b0, 8, $sformatf("sweep %0d/%0d", p, b));
        end
      end
    end
  endtask

  initial begin
    fork
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
      end
    join_none
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
